// File: rtl/glyph_serializer.sv
// glyph_serializer: captures an 8x8 glyph from the char ROM and streams
// it as 64 row-major FG/BG pixels on valid/ready. Option: OVERRUN_FLAG_EN.
module glyph_serializer #(
    parameter int                 COLOR_W  = 8,
    parameter logic [COLOR_W-1:0] FG_COLOR = 8'hFF,
    parameter logic [COLOR_W-1:0] BG_COLOR = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               charprint,
    input  logic [63:0]        vdata,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [2:0]         pix_x,
    output logic [2:0]         pix_y,
    output logic               pix_on,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               done
`ifdef OVERRUN_FLAG_EN
    ,
    output logic               overrun
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [63:0]        glyph_q;
    logic [5:0]         idx_q;
    logic [5:0]         idx_d;
    logic               pix_valid_q;
    logic [2:0]         pix_x_q;
    logic [2:0]         pix_y_q;
    logic               pix_on_q;
    logic               pix_on_d;
    logic [COLOR_W-1:0] pix_color_q;
    logic               busy_q;
    logic               done_q;
    logic               xfer;

    // Pixel colour lookup for a single glyph bit.
    function automatic logic [COLOR_W-1:0] color_of(input logic b);
        return b ? FG_COLOR : BG_COLOR;
    endfunction

    assign xfer = pix_valid_q & pix_ready;

    // Next pixel index and its glyph bit; bit 63-idx is simply ~idx.
    always_comb begin
        idx_d    = idx_q + 6'd1;
        pix_on_d = glyph_q[~idx_d];
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            glyph_q     <= '0;
            idx_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_on_q    <= 1'b0;
            pix_color_q <= BG_COLOR;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (charprint) begin
                        state_q <= WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    state_q     <= EMIT;
                    glyph_q     <= vdata;
                    idx_q       <= '0;
                    pix_valid_q <= 1'b1;
                    pix_x_q     <= '0;
                    pix_y_q     <= '0;
                    pix_on_q    <= vdata[63];
                    pix_color_q <= color_of(vdata[63]);
                end
                EMIT: begin
                    if (xfer) begin
                        idx_q <= idx_d;
                        if (idx_q == 6'd63) begin
                            state_q     <= DONE;
                            pix_valid_q <= 1'b0;
                            pix_x_q     <= '0;
                            pix_y_q     <= '0;
                            pix_on_q    <= 1'b0;
                            pix_color_q <= BG_COLOR;
                            done_q      <= 1'b1;
                        end else begin
                            pix_x_q     <= idx_d[2:0];
                            pix_y_q     <= idx_d[5:3];
                            pix_on_q    <= pix_on_d;
                            pix_color_q <= color_of(pix_on_d);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef OVERRUN_FLAG_EN
    logic overrun_q;

    // Sticky record of a render request dropped while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (charprint && busy_q) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_on    = pix_on_q;
    assign pix_color = pix_color_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_glyph_serializer.sv
// tb_glyph_serializer: directed bench for glyph_serializer.
// Define OVERRUN_FLAG_EN for both files to exercise the overrun flag.
module tb_glyph_serializer;

    logic        clk;
    logic        reset;
    logic        charprint;
    logic [63:0] vdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [2:0]  pix_x;
    logic [2:0]  pix_y;
    logic        pix_on;
    logic [7:0]  pix_color;
    logic        busy;
    logic        done;
`ifdef OVERRUN_FLAG_EN
    logic        overrun;
`endif

    int n_cmp = 0;
    int n_err = 0;

    glyph_serializer #(
        .COLOR_W (8),
        .FG_COLOR(8'hFF),
        .BG_COLOR(8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .charprint(charprint),
        .vdata    (vdata),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_on   (pix_on),
        .pix_color(pix_color),
        .busy     (busy),
        .done     (done)
`ifdef OVERRUN_FLAG_EN
        ,
        .overrun  (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the whole pixel bundle against pixel k of glyph v.
    task automatic chk_pix(input string tag, input int k,
                           input logic [63:0] v);
        logic [15:0] obs;
        logic [15:0] exp;
        logic        on;
        on  = v[63-k];
        obs = {pix_valid, pix_y, pix_x, pix_on, pix_color};
        exp = {1'b1, k[5:3], k[2:0], on, (on ? 8'hFF : 8'h00)};
        chk(tag, 64'(obs), 64'(exp));
    endtask

    // Issue charprint, present v during WAIT, then garbage afterwards.
    task automatic start_glyph(input logic [63:0] v);
        charprint = 1'b1;
        vdata     = ~v;
        tick();
        charprint = 1'b0;
        vdata     = v;
        chk("wait_busy", 64'(busy), 64'(1'b1));
        chk("wait_valid", 64'(pix_valid), 64'(1'b0));
        tick();
        vdata = ~v;
    endtask

    task automatic emit(input string tag, input logic [63:0] v,
                        input int from, input int to);
        pix_ready = 1'b1;
        for (int k = from; k < to; k++) begin
            chk_pix(tag, k, v);
            tick();
        end
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, 64'({pix_valid, done, busy}),
            64'(3'b011));
        tick();
        chk({tag, "_idle"}, 64'({pix_valid, done, busy}),
            64'(3'b000));
    endtask

    initial begin
        int xf;
        int cyc;
        reset     = 1'b1;
        charprint = 1'b0;
        vdata     = '0;
        pix_ready = 1'b0;

        // 1: reset then idle
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_outs", 64'({pix_valid, pix_x, pix_y, pix_on, busy, done}),
            64'(0));
        chk("rst_color", 64'(pix_color), 64'(8'h00));
`ifdef OVERRUN_FLAG_EN
        chk("rst_ovr", 64'(overrun), 64'(1'b0));
`endif

        // 2: corner pixels, back-to-back
        pix_ready = 1'b1;
        start_glyph(64'h8000_0000_0000_0001);
        emit("t2_pix", 64'h8000_0000_0000_0001, 0, 64);
        chk_done("t2");

        // 3: alternating rows, ready toggles each cycle
        start_glyph(64'hFF00_FF00_FF00_FF00);
        xf  = 0;
        cyc = 0;
        while (xf < 64 && cyc < 300) begin
            pix_ready = (cyc % 2 == 0);
            chk_pix("t3_pix", xf, 64'hFF00_FF00_FF00_FF00);
            tick();
            if (pix_ready) xf++;
            cyc++;
        end
        chk("t3_xfers", 64'(xf), 64'(64));
        chk("t3_cycles", 64'(cyc), 64'(127));
        chk_done("t3");

        // 4: second charprint mid-stream is dropped
        start_glyph(64'h0123_4567_89AB_CDEF);
        emit("t4_pix", 64'h0123_4567_89AB_CDEF, 0, 20);
        charprint = 1'b1;
        vdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        chk_pix("t4_pix20", 20, 64'h0123_4567_89AB_CDEF);
        tick();
        charprint = 1'b0;
        emit("t4_pix", 64'h0123_4567_89AB_CDEF, 21, 64);
`ifdef OVERRUN_FLAG_EN
        chk("t4_ovr", 64'(overrun), 64'(1'b1));
`endif
        chk_done("t4");
        tick();
        chk("t4_stays_idle", 64'({busy, pix_valid}), 64'(2'b00));
`ifdef OVERRUN_FLAG_EN
        chk("t4_ovr_sticky", 64'(overrun), 64'(1'b1));
`endif

        // 5: reset mid-glyph aborts, fresh glyph afterwards
        start_glyph(64'hFFFF_FFFF_FFFF_FFFF);
        emit("t5_pix", 64'hFFFF_FFFF_FFFF_FFFF, 0, 30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_abort", 64'({pix_valid, busy, done}), 64'(3'b000));
        chk("t5_color", 64'(pix_color), 64'(8'h00));
`ifdef OVERRUN_FLAG_EN
        chk("t5_ovr_clr", 64'(overrun), 64'(1'b0));
`endif
        tick();
        tick();
        chk("t5_no_done", 64'({pix_valid, busy, done}), 64'(3'b000));
        start_glyph(64'h5555_5555_5555_5555);
        emit("t5_fresh", 64'h5555_5555_5555_5555, 0, 64);
        chk_done("t5");

        // 6: charprint during DONE is ignored
        start_glyph(64'h0F0F_0F0F_0F0F_0F0F);
        emit("t6_pix", 64'h0F0F_0F0F_0F0F_0F0F, 0, 64);
        chk("t6_in_done", 64'(done), 64'(1'b1));
        charprint = 1'b1;
        tick();
        charprint = 1'b0;
        chk("t6_ignored", 64'({busy, done, pix_valid}), 64'(3'b000));
        tick();
        chk("t6_still_idle", 64'({busy, pix_valid}), 64'(2'b00));
`ifdef OVERRUN_FLAG_EN
        chk("t6_ovr", 64'(overrun), 64'(1'b1));
`endif
        start_glyph(64'hA5A5_A5A5_A5A5_A5A5);
        emit("t6_next", 64'hA5A5_A5A5_A5A5_A5A5, 0, 64);
        chk_done("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
